// File: rtl/in_debounce.sv
// in_debounce: synchronise, debounce, invert and edge-detect active-low input pins.
// Optional IN_LATCH_EN adds sticky per-bit pend flags with pend_clr and pend_any.
module in_debounce #(
  parameter int N_IN      = 10,
  parameter int DB_CYCLES = 16,
  parameter int CNT_W     = $clog2(DB_CYCLES) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_IN-1:0] pins,
  input  logic [N_IN-1:0] pend_clr,
  output logic [15:0]     in_out,
  output logic [N_IN-1:0] rise,
  output logic [N_IN-1:0] pend,
  output logic            pend_any
);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);
  logic [N_IN-1:0]  s1_q, s2_q, lvl, stable_q, stable_d, rise_q, rise_d;
  logic [CNT_W-1:0] cnt_q [N_IN];
  logic [CNT_W-1:0] cnt_d [N_IN];
  assign lvl = ~s2_q;
  // A new level is accepted only after CNT_MAX+1 consecutive mismatching edges.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < N_IN; i++) begin
      cnt_d[i]    = (lvl[i] == stable_q[i] || cnt_q[i] == CNT_MAX) ? '0 : cnt_q[i] + 1'b1;
      stable_d[i] = (lvl[i] != stable_q[i] && cnt_q[i] == CNT_MAX) ? lvl[i] : stable_q[i];
    end
    rise_d = stable_d & ~stable_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q     <= '1;
      s2_q     <= '1;
      stable_q <= '0;
      rise_q   <= '0;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else begin
      s1_q     <= pins;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      for (int i = 0; i < N_IN; i++) cnt_q[i] <= cnt_d[i];
    end
  end
  assign in_out = 16'(stable_q);
  assign rise   = rise_q;
`ifdef IN_LATCH_EN
  logic [N_IN-1:0] pend_q, pend_d;
  logic            pend_any_q;
  // A rise on the same edge as a clear keeps the flag set.
  assign pend_d = rise_d | (pend_q & ~pend_clr);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q     <= '0;
      pend_any_q <= 1'b0;
    end else begin
      pend_q     <= pend_d;
      pend_any_q <= |pend_d;
    end
  end
  assign pend     = pend_q;
  assign pend_any = pend_any_q;
`else
  logic unused_pend_clr;
  assign unused_pend_clr = ^pend_clr;
  assign pend     = '0;
  assign pend_any = 1'b0;
`endif
endmodule

// File: tb/tb_in_debounce.sv
// tb_in_debounce: scoreboard bench for in_debounce with DB_CYCLES=4, N_IN=10.
module tb_in_debounce;
`ifdef IN_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pins, pend_clr, rise, pend;
  logic [15:0] in_out;
  logic        pend_any;
  int          n_cmp = 0;
  int          n_bad = 0;
  typedef struct packed {
    logic [15:0] i;
    logic [9:0]  r;
    logic [9:0]  p;
  } exp_t;
  exp_t sb[$];

  in_debounce #(.N_IN(10), .DB_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .pins(pins), .pend_clr(pend_clr),
    .in_out(in_out), .rise(rise), .pend(pend), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: act=%h exp=%h @%0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc(input string tag, input logic [9:0] p, input logic [9:0] c,
                     input logic [15:0] ei, input logic [9:0] er, input logic [9:0] ep);
    exp_t e;
    pins     = p;
    pend_clr = c;
    sb.push_back('{ei, er, LATCH ? ep : 10'h0});
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk({tag, ".in"}, 32'(in_out), 32'(e.i));
    chk({tag, ".rise"}, 32'(rise), 32'(e.r));
    chk({tag, ".pend"}, 32'(pend), 32'(e.p));
    chk({tag, ".any"}, 32'(pend_any), 32'(|e.p));
  endtask

  task automatic run(input string tag, input logic [9:0] p, input logic [9:0] c, input int n,
                     input logic [15:0] ei, input logic [9:0] er, input logic [9:0] ep);
    for (int k = 0; k < n; k++) cyc(tag, p, c, ei, er, ep);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".in"}, 32'(in_out), 32'h0);
    chk({tag, ".rise"}, 32'(rise), 32'h0);
    chk({tag, ".pend"}, 32'(pend), 32'h0);
    chk({tag, ".any"}, 32'(pend_any), 32'h0);
  endtask

  initial begin
    reset    = 1'b0;
    pins     = 10'h3FF;
    pend_clr = 10'h0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    reset = 1'b1;
    run("idle", 10'h3FF, 10'h0, 20, 16'h0, 10'h0, 10'h0);
    run("press_wait", 10'h3FE, 10'h0, 5, 16'h0, 10'h0, 10'h0);
    cyc("press_acc", 10'h3FE, 10'h0, 16'h1, 10'h1, 10'h1);
    run("press_hold", 10'h3FE, 10'h0, 3, 16'h1, 10'h0, 10'h1);
    run("rel_wait", 10'h3FF, 10'h0, 5, 16'h1, 10'h0, 10'h1);
    cyc("rel_acc", 10'h3FF, 10'h0, 16'h0, 10'h0, 10'h1);
    cyc("clr0", 10'h3FF, 10'h1, 16'h0, 10'h0, 10'h0);
    run("gl_a", 10'h3F7, 10'h0, 3, 16'h0, 10'h0, 10'h0);
    cyc("gl_gap", 10'h3FF, 10'h0, 16'h0, 10'h0, 10'h0);
    run("gl_b", 10'h3F7, 10'h0, 3, 16'h0, 10'h0, 10'h0);
    run("gl_quiet", 10'h3FF, 10'h0, 8, 16'h0, 10'h0, 10'h0);
    run("gl4_wait", 10'h3F7, 10'h0, 4, 16'h0, 10'h0, 10'h0);
    cyc("gl4_wait", 10'h3FF, 10'h0, 16'h0, 10'h0, 10'h0);
    cyc("gl4_acc", 10'h3FF, 10'h0, 16'h8, 10'h8, 10'h8);
    run("gl4_hold", 10'h3FF, 10'h0, 3, 16'h8, 10'h0, 10'h8);
    cyc("gl4_rel", 10'h3FF, 10'h0, 16'h0, 10'h0, 10'h8);
    cyc("clr3", 10'h3FF, 10'h8, 16'h0, 10'h0, 10'h0);
    run("multi_wait", 10'h000, 10'h0, 5, 16'h0, 10'h0, 10'h0);
    cyc("multi_acc", 10'h000, 10'h0, 16'h3FF, 10'h3FF, 10'h3FF);
    run("multi_hold", 10'h000, 10'h0, 2, 16'h3FF, 10'h0, 10'h3FF);
    run("mid", 10'h3FF, 10'h0, 3, 16'h3FF, 10'h0, 10'h3FF);
    pins = 10'h000;
    #2 reset = 1'b0;
    #1 chk_zero("rst_async");
    @(negedge clk);
    reset = 1'b1;
    run("rst_wait", 10'h000, 10'h0, 5, 16'h0, 10'h0, 10'h0);
    cyc("rst_acc", 10'h000, 10'h0, 16'h3FF, 10'h3FF, 10'h3FF);
    run("all_rel", 10'h3FF, 10'h0, 5, 16'h3FF, 10'h0, 10'h3FF);
    cyc("all_rel_acc", 10'h3FF, 10'h0, 16'h0, 10'h0, 10'h3FF);
    cyc("clr_all", 10'h3FF, 10'h3FF, 16'h0, 10'h0, 10'h0);
    run("b5_wait", 10'h3DF, 10'h0, 5, 16'h0, 10'h0, 10'h0);
    cyc("b5_acc", 10'h3DF, 10'h0, 16'h20, 10'h20, 10'h20);
    cyc("b5_hold", 10'h3DF, 10'h0, 16'h20, 10'h0, 10'h20);
    cyc("b5_clr", 10'h3DF, 10'h20, 16'h20, 10'h0, 10'h0);
    run("b5_rel", 10'h3FF, 10'h0, 5, 16'h20, 10'h0, 10'h0);
    cyc("b5_rel_acc", 10'h3FF, 10'h0, 16'h0, 10'h0, 10'h0);
    run("b5b_wait", 10'h3DF, 10'h20, 5, 16'h0, 10'h0, 10'h0);
    cyc("set_wins", 10'h3DF, 10'h20, 16'h20, 10'h20, 10'h20);
    cyc("b5b_hold", 10'h3DF, 10'h0, 16'h20, 10'h0, 10'h20);
    cyc("b5b_clr", 10'h3DF, 10'h20, 16'h20, 10'h0, 10'h0);
    cyc("b5b_idle", 10'h3DF, 10'h0, 16'h20, 10'h0, 10'h0);
    chk("sb_empty", 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
